score_counter: RTL and testbench
================================

// Module: score_counter
// PURPOSE
//   Score producer for the two-digit seven-segment score display decoder.
//   Accepts hit events carrying a point value and queues them as pending points.
//   Credits pending points to the displayed score one per clock, so the display counts up visibly.
//   Provides the score as a 32-bit binary value (0..MAX_SCORE) for the display decoder,
//   plus BCD tens/ones digits; game control uses the start / game_over interface.
// PARAMETERS
//   MAX_SCORE  99   saturation value of score; must be <= 99 (two display digits)
//   PEND_W     8    width of pending-points accumulator; saturates at 2**PEND_W-1
// PORTS
//   clk        in   1   system clock; all state updates on rising edge
//   rst        in   1   synchronous, active-high reset
//   start      in   1   1-cycle pulse: begin/restart a game
//   hit        in   1   1-cycle pulse: enemy destroyed
//   hit_pts    in   4   points for this hit (0..15), sampled when hit=1
//   game_over  in   1   1-cycle pulse: player died
//   score      out  32  current score, binary, 0..MAX_SCORE, bits [31:7] always 0
//   tens       out  4   BCD tens digit of score
//   ones       out  4   BCD ones digit of score
//   busy       out  1   1 while pending points != 0
//   saturated  out  1   1 once score == MAX_SCORE in current game
//   hiscore    out  32  best score since reset (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE; score=0, tens=0, ones=0, pending=0, busy=0, saturated=0, hiscore=0.
//   All outputs registered. score, tens and ones always change together in the same cycle.
//   FSM states:
//     IDLE  hits ignored; start -> RUN.
//     RUN   hits accepted; game_over -> OVER.
//           start while in RUN -> RUN with restart clear.
//     OVER  new hits ignored; pending keeps draining; start -> RUN.
//   Entering RUN via start: next cycle score=0, digits=0, pending=0, saturated=0.
//     A hit in the same cycle as start is dropped.
//   start and game_over in the same cycle: start wins (-> RUN, cleared).
//   Accumulate (RUN, hit=1): pending_next = pending + hit_pts - dec, where dec=1 if
//     a credit occurs this cycle. Result clamps at 2**PEND_W-1. hit_pts=0 is a no-op.
//   Credit: when pending!=0 and score<MAX_SCORE, in the same cycle:
//     score+=1, pending-=1 (net of any new hit).
//     BCD ones wraps 9->0 with tens+1.
//     Hit latency: pts on cycle N -> first increment visible on cycle N+1.
//     Drain rate is 1 point/cycle.
//   Saturation: when score reaches MAX_SCORE, saturated=1 on the same edge.
//     Pending is cleared to 0 on the next edge; further hits are discarded.
//     score never exceeds MAX_SCORE.
//   busy = (pending != 0), registered.
//   Reset mid-drain: everything returns to reset values on the next edge; pending is lost.
// CONFIGURATION
//   SCORE_HISCORE_EN defined:
//     hiscore tracks the maximum score reached since reset.
//     Updated the cycle after score exceeds it.
//     Not cleared by start; cleared only by rst.
//   Not defined: hiscore port present, constantly 0; no register inferred.
// TESTING
//   1 rst, start, hit pts=5 -> busy=1; score 1,2,3,4,5 on following 5 cycles; busy=0 after; tens=0, ones=5.
//   2 RUN score=8, hit pts=4 -> score 9 then 10: tens=1, ones=0 (BCD carry); final 12.
//   3 RUN score=97, hit pts=15 -> score 98,99; saturated=1; pending 0 next cycle; later hit pts=3 -> score stays 99.
//   4 hit pts=6 then game_over next cycle, then hit pts=9 in OVER -> score drains to 6 only; state OVER.
//   5 start and game_over same cycle at score=40 -> score=0, state RUN; hit pts=2 same cycle as start -> dropped.
//   6 SCORE_HISCORE_EN: game to 30, start, game to 12 -> hiscore=30; rst -> hiscore=0; without macro hiscore always 0.

Source files
------------

// File: rtl/score_counter.sv
// Score producer for the two-digit seven-segment score display.
// Hits queue points in a pending accumulator; one point per clock is credited
// to the score (binary plus BCD digits) until the score saturates at MAX_SCORE.
// Optional feature macro: SCORE_HISCORE_EN (best score since reset on hiscore).
module score_counter #(
  parameter int MAX_SCORE = 99,
  parameter int PEND_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hit,
  input  logic [3:0]  hit_pts,
  input  logic        game_over,
  output logic [31:0] score,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic        busy,
  output logic        saturated,
  output logic [31:0] hiscore
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [6:0]      MAX7     = 7'(MAX_SCORE);
  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

  state_t            state, state_nxt;
  logic [6:0]        score_r;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic [PEND_W:0]   sum;
  logic              credit;

  // A credit happens whenever points are queued and there is room below the cap.
  assign credit = (pend != '0) && (score_r < MAX7);

  // Game control; start overrides game_over in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (start) state_nxt = RUN;
               else if (game_over) state_nxt = OVER;
      OVER:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Pending accumulator: drain one per credit, add accepted hits, clamp at all-ones.
  // Once saturated the queue is flushed and further hits are discarded.
  always_comb begin
    sum = {1'b0, pend} - {{PEND_W{1'b0}}, credit};
    if (state == RUN && hit && !saturated)
      sum = sum + {{(PEND_W-3){1'b0}}, hit_pts};
    pend_nxt = (sum > PEND_MAX) ? {PEND_W{1'b1}} : sum[PEND_W-1:0];
    if (saturated)
      pend_nxt = '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Score, digits, pending and flags; start clears the game (dropping any same-cycle hit).
  always_ff @(posedge clk) begin
    if (rst || start) begin
      score_r   <= '0;
      tens      <= '0;
      ones      <= '0;
      pend      <= '0;
      busy      <= 1'b0;
      saturated <= 1'b0;
    end else begin
      pend <= pend_nxt;
      busy <= (pend_nxt != '0);
      if (credit) begin
        score_r <= score_r + 7'd1;
        if (ones == 4'd9) begin
          ones <= 4'd0;
          tens <= tens + 4'd1;
        end else begin
          ones <= ones + 4'd1;
        end
        if (score_r + 7'd1 == MAX7)
          saturated <= 1'b1;
      end
    end
  end

  assign score = {25'd0, score_r};

`ifdef SCORE_HISCORE_EN
  logic [6:0] hi_r;

  // Best score since reset; a new game does not clear it.
  always_ff @(posedge clk) begin
    if (rst)                 hi_r <= '0;
    else if (score_r > hi_r) hi_r <= score_r;
  end

  assign hiscore = {25'd0, hi_r};
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: directed stimulus, a cycle-level behavioural model
// compared against every output each cycle, and literal checks that pin the model.
module tb_score_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        hit = 1'b0;
  logic [3:0]  hit_pts = 4'd0;
  logic        game_over = 1'b0;
  logic [31:0] score;
  logic [3:0]  tens, ones;
  logic        busy, saturated;
  logic [31:0] hiscore;

  int errors = 0;
  int checks = 0;

  localparam int MAXS = 99;
  localparam int PMAX = 255;

  score_counter dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .hit_pts(hit_pts),
    .game_over(game_over), .score(score), .tens(tens), .ones(ones),
    .busy(busy), .saturated(saturated), .hiscore(hiscore)
  );

  always #5 clk = ~clk;

  // Model of the game: 0 idle, 1 running, 2 over.
  typedef struct {
    int st;
    int sc;
    int pd;
    int sat;
    int hi;
  } mstate_t;

  mstate_t m = '{0, 0, 0, 0, 0};
  bit mvalid = 1'b0;

  function automatic mstate_t mnext(mstate_t c, bit r, bit s, bit h, int p, bit g);
    mstate_t n = c;
    int cr;
    if (r) return '{0, 0, 0, 0, 0};
    n.hi = (c.sc > c.hi) ? c.sc : c.hi;
    if (s) begin
      n.st = 1; n.sc = 0; n.pd = 0; n.sat = 0;
      return n;
    end
    cr = (c.pd > 0 && c.sc < MAXS) ? 1 : 0;
    n.pd = c.pd - cr;
    if (c.sat != 0) n.pd = 0;
    else if (c.st == 1 && h) n.pd = (n.pd + p > PMAX) ? PMAX : n.pd + p;
    n.sc = c.sc + cr;
    if (cr == 1 && n.sc == MAXS) n.sat = 1;
    if (c.st == 1 && g) n.st = 2;
    return n;
  endfunction

  // Model advances on the same edge as the DUT, from the same sampled inputs.
  always @(posedge clk) begin
    if (rst) mvalid <= 1'b1;
    m <= mnext(m, rst, start, hit, int'(hit_pts), game_over);
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("score", score, m.sc);
      chk("tens", tens, m.sc / 10);
      chk("ones", ones, m.sc % 10);
      chk("busy", busy, (m.pd != 0) ? 1 : 0);
      chk("saturated", saturated, m.sat);
`ifdef SCORE_HISCORE_EN
      chk("hiscore", hiscore, m.hi);
`else
      chk("hiscore", hiscore, 0);
`endif
    end
  end

  task automatic pulse(input bit s, input bit h, input int p, input bit g);
    @(negedge clk);
    start = s; hit = h; hit_pts = 4'(p); game_over = g;
    @(negedge clk);
    start = 0; hit = 0; hit_pts = 0; game_over = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    // Reset state
    rst = 1;
    wait_cyc(2);
    rst = 0;
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hiscore", hiscore, 0);

    // 1: five points drain one per cycle
    pulse(1, 0, 0, 0);
    pulse(0, 1, 5, 0);
    chk("t1_busy", busy, 1);
    chk("t1_score0", score, 0);
    wait_cyc(5);
    chk("t1_score", score, 5);
    chk("t1_ones", ones, 5);
    chk("t1_tens", tens, 0);
    chk("t1_idle", busy, 0);

    // 2: BCD carry 9 -> 10
    pulse(1, 0, 0, 0);
    pulse(0, 1, 8, 0);
    wait_cyc(8);
    chk("t2_score8", score, 8);
    pulse(0, 1, 4, 0);
    wait_cyc(2);
    chk("t2_tens", tens, 1);
    chk("t2_ones", ones, 0);
    wait_cyc(2);
    chk("t2_score12", score, 12);

    // 3: saturation at 99
    pulse(1, 0, 0, 0);
    repeat (6) pulse(0, 1, 15, 0);
    pulse(0, 1, 7, 0);
    wait_cyc(100);
    chk("t3_score97", score, 97);
    pulse(0, 1, 15, 0);
    wait_cyc(2);
    chk("t3_score99", score, 99);
    chk("t3_sat", saturated, 1);
    chk("t3_busy_at_sat", busy, 1);
    wait_cyc(1);
    chk("t3_flushed", busy, 0);
    pulse(0, 1, 3, 0);
    wait_cyc(3);
    chk("t3_hold99", score, 99);
    chk("t3_hold_busy", busy, 0);

    // 4: game_over the cycle after a hit; hits in OVER ignored, queue drains
    pulse(1, 0, 0, 0);
    @(negedge clk); hit = 1; hit_pts = 6;
    @(negedge clk); hit = 0; hit_pts = 0; game_over = 1;
    @(negedge clk); game_over = 0; hit = 1; hit_pts = 9;
    @(negedge clk); hit = 0; hit_pts = 0;
    wait_cyc(20);
    chk("t4_score6", score, 6);
    chk("t4_busy", busy, 0);

    // 5: start + game_over + hit together at score 40
    pulse(1, 0, 0, 0);
    pulse(0, 1, 15, 0);
    pulse(0, 1, 15, 0);
    pulse(0, 1, 10, 0);
    wait_cyc(60);
    chk("t5_score40", score, 40);
    pulse(1, 1, 2, 1);
    chk("t5_cleared", score, 0);
    chk("t5_drop", busy, 0);
    wait_cyc(3);
    chk("t5_still0", score, 0);
    pulse(0, 1, 3, 0);
    wait_cyc(5);
    chk("t5_run", score, 3);

    // 6: hiscore survives start, cleared by rst; reset mid-drain
    do_reset();
    pulse(1, 0, 0, 0);
    pulse(0, 1, 15, 0);
    pulse(0, 1, 15, 0);
    wait_cyc(40);
    chk("t6_score30", score, 30);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 12, 0);
    wait_cyc(20);
    chk("t6_score12", score, 12);
`ifdef SCORE_HISCORE_EN
    chk("t6_hiscore", hiscore, 30);
`else
    chk("t6_hiscore", hiscore, 0);
`endif
    pulse(0, 1, 9, 0);
    wait_cyc(2);
    chk("t6_mid_busy", busy, 1);
    do_reset();
    chk("t6_rst_score", score, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_hiscore", hiscore, 0);
    wait_cyc(5);
    chk("t6_lost_pend", score, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
